lsu_bus_ctrl: RTL and testbench
===============================

Name: lsu_bus_ctrl

Overview:
- Sequential successor to the combinational load/store stage.
- Accepts one load/store uop from EXU and drives a req/gnt/rvalid data bus, stalling the pipeline until the response returns.
- Performs little-endian byte-lane steering and sign/zero extension, detects misalignment, and flags bus errors and response timeouts as access faults.
- Optionally splits misaligned accesses into two aligned bus transactions.

Parameters:
- ADDR_W, 32, width of the bus address.
- MISALIGN_SPLIT, 0. 0: misaligned access raises an exception. 1: misaligned access is split into two aligned accesses.
- TIMEOUT_CYCLES, 255. Cycles spent waiting in REQ+RESP before an access fault is declared. Must be ≥1.
- TO_W, 8. Timeout counter width. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock
- n_rst_i  in  1  reset, synchronous, active-low
- req_valid_i  in  1  uop presented by EXU
- uop_i  in  `AluOpBus  UOP_LB/LBU/LH/LHU/LW/SB/SH/SW; any other value is a non-memory op
- addr_i  in  ADDR_W  effective address
- wdata_i  in  32  store data
- rd_wa_i  in  `RegAddrBus  load destination register
- stall_req_o  out  1  to ctrl; holds the pipeline
- done_o  out  1  one-cycle completion pulse
- rd_we_o, rd_a_o, rd_wd_o  out  1/`RegAddrBus/32  load writeback; valid only while done_o=1
- exc_o  out  3  {access_fault, load_misalign, store_misalign}; valid only while done_o=1
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  request accepted
- bus_we_o  out  1  bus write
- bus_addr_o  out  ADDR_W  word-aligned bus address
- bus_sel_o  out  4  byte enables
- bus_wdata_o  out  32  lane-steered store data
- bus_rvalid_i  in  1  response valid
- bus_rdata_i  in  32  read data
- bus_err_i  in  1  bus error; qualified by bus_rvalid_i

Behaviour:
- Reset (n_rst_i=0 at a clk_i edge): state=IDLE. All outputs 0: stall_req_o, done_o, rd_we_o, rd_a_o, rd_wd_o, exc_o, bus_*. Reset during any state aborts the transaction; no completion is reported.
- States: IDLE, REQ, RESP, DONE, plus a phase bit (0/1) used only for split accesses.

IDLE
- Accepts when req_valid_i=1 and uop_i is a memory op. Latches uop, addr, offset=addr[1:0], rd_wa, wdata.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]≠0.
- Misaligned and MISALIGN_SPLIT=0: go to DONE with load_misalign or store_misalign set. No bus activity.
- Otherwise: go to REQ, phase=0.
- stall_req_o is combinational: 1 in an accepting IDLE cycle, 1 in REQ and RESP, 0 in DONE and in a non-accepting IDLE.

REQ
- bus_req_o=1.
- bus_addr_o = {addr[ADDR_W-1:2],2'b00}, plus 4 when phase=1.
- bus_we_o=1 for stores.
- Lanes: byte b is at bus_wdata_o[8b+7:8b] and bus_sel_o[b].
  - Phase 0: sel = size mask << offset, truncated to 4 bits; wdata = wdata << 8*offset.
  - Phase 1: sel = the bits shifted out above bit 3; wdata = wdata >> 8*(4-offset).
- bus_gnt_i=1 → RESP. Outputs hold stable until granted.

RESP
- bus_req_o=0. Waits for bus_rvalid_i. Stores also wait for rvalid as the write acknowledge.
- rvalid with bus_err_i=1: access_fault=1, go to DONE. Phase 1 is not issued.
- rvalid on phase 0 of a split access: capture rdata, set phase=1, go to REQ.
- rvalid otherwise: merge data, go to DONE.

Merge and extension
- Merged data is {phase1_rdata, phase0_rdata} >> 8*offset, taking the low 32 bits.
- LB/LH: sign-extended. LBU/LHU: zero-extended. LW: full 32 bits.

Timeout
- Counter clears on acceptance and increments every cycle spent in REQ or RESP.
- When it reaches TIMEOUT_CYCLES: access_fault=1, bus_req_o drops, go to DONE.
- rvalid arriving in the same cycle as the timeout wins.

DONE
- Registered outputs: done_o=1. rd_we_o=1 only for a load with no exception. rd_a_o and rd_wd_o valid. exc_o valid.
- Next state is IDLE unconditionally. req_valid_i is ignored in DONE because the pipeline advances in this cycle.
- The next cycle clears done_o, rd_we_o and exc_o.

Latency
- Aligned access with immediate gnt and rvalid one cycle after gnt: accept at cycle N, REQ at N+1, RESP at N+2, done_o at N+3.
- A split access adds 2 cycles.
- A non-split misaligned access gives done_o at N+1.

Other rules
- Non-memory uop with req_valid_i=1: ignored, no stall.
- bus_rvalid_i outside RESP is ignored.

Decomposition:
- Shared defines file (existing): uop codes, `RegBus, `AluOpBus, `RegAddrBus.
- Add there: exc_o bit positions (EXC_ST_MISALIGN=0, EXC_LD_MISALIGN=1, EXC_ACC_FAULT=2) and LSU state encodings.
- Sub-module lsu_lane: combinational size/offset/phase → sel, shifted wdata, and merged/extended read data. Shared by the REQ and DONE paths.

Test Plan:
1. LW, addr=0x100, gnt immediate, rvalid+rdata=0xDEADBEEF one cycle later → bus_addr 0x100, sel 1111, done_o at N+3, rd_wd_o=0xDEADBEEF, rd_we_o=1.
2. LB, addr=0x103, rdata=0x80xxxxxx → sel 1000, rd_wd_o=0xFFFFFF80. LBU at the same address → 0x00000080.
3. SH, addr=0x202, wdata=0x1234 → sel 1100, bus_wdata[31:16]=0x1234, bus_we_o=1. Response has rvalid=1, err=0 → done_o, rd_we_o=0, exc_o=000.
4. MISALIGN_SPLIT=0, LW at 0x101 → no bus_req_o, done_o at N+1, exc_o=010. MISALIGN_SPLIT=1, LW at 0x101 with words 0x44332211 at 0x100 and 0x88776655 at 0x104 → two requests (sel 1110 then 0001), rd_wd_o=0x55443322.
5. gnt withheld for 10 cycles → bus_req_o and stall_req_o stay high with stable address. TIMEOUT_CYCLES=4 and no rvalid → exc_o=100, done_o pulses. rvalid with err=1 → exc_o=100, rd_we_o=0.
6. n_rst_i=0 during RESP → all outputs 0 next cycle. A late rvalid then arriving while in IDLE is ignored.

Source files
------------

// File: rtl/lsu_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_ctrl_pkg
// Purpose  : Shared types, uop codes, exception bit positions and LSU state
//            encodings for the sequential load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_bus_ctrl_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int REG_ADDR_W = 5;

  typedef logic [ALU_OP_W-1:0]   alu_op_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Memory uop codes; every other value is treated as a non-memory op.
  localparam alu_op_t UOP_NOP = 8'h00;
  localparam alu_op_t UOP_LB  = 8'h20;
  localparam alu_op_t UOP_LH  = 8'h21;
  localparam alu_op_t UOP_LW  = 8'h22;
  localparam alu_op_t UOP_LBU = 8'h24;
  localparam alu_op_t UOP_LHU = 8'h25;
  localparam alu_op_t UOP_SB  = 8'h28;
  localparam alu_op_t UOP_SH  = 8'h29;
  localparam alu_op_t UOP_SW  = 8'h2A;

  // Bit positions inside exc_o.
  localparam int EXC_ST_MISALIGN = 0;
  localparam int EXC_LD_MISALIGN = 1;
  localparam int EXC_ACC_FAULT   = 2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } lsu_size_e;

  function automatic logic is_mem_op(input alu_op_t op);
    case (op)
      UOP_LB, UOP_LH, UOP_LW, UOP_LBU, UOP_LHU,
      UOP_SB, UOP_SH, UOP_SW: is_mem_op = 1'b1;
      default:                is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input alu_op_t op);
    is_store = (op == UOP_SB) || (op == UOP_SH) || (op == UOP_SW);
  endfunction

  function automatic logic is_unsigned(input alu_op_t op);
    is_unsigned = (op == UOP_LBU) || (op == UOP_LHU);
  endfunction

  function automatic lsu_size_e op_size(input alu_op_t op);
    case (op)
      UOP_LB, UOP_LBU, UOP_SB: op_size = SIZE_B;
      UOP_LH, UOP_LHU, UOP_SH: op_size = SIZE_H;
      default:                 op_size = SIZE_W;
    endcase
  endfunction

  // Byte-enable pattern of an access placed at lane 0.
  function automatic logic [3:0] size_mask(input lsu_size_e sz);
    case (sz)
      SIZE_B:  size_mask = 4'b0001;
      SIZE_H:  size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_bus_ctrl_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane
// Purpose  : Little-endian byte-lane steering. Produces byte enables and
//            shifted store data for either phase of an access, and merges /
//            extends returned read data.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane
  import lsu_bus_ctrl_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic [1:0]  offset_i,
  input  logic        phase_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_lo_i,
  input  logic [31:0] rdata_hi_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  w_sel_wide;
  logic [63:0] w_wdata_wide;
  logic [63:0] w_rdata_wide;
  logic [31:0] w_rdata_sh;

  // Steer into a two-word window: low word is phase 0, high word is phase 1.
  always_comb begin
    w_sel_wide   = {4'b0000, size_mask(size_i)} << offset_i;
    w_wdata_wide = {32'h0000_0000, wdata_i} << {offset_i, 3'b000};
    w_rdata_wide = {rdata_hi_i, rdata_lo_i} >> {offset_i, 3'b000};
    w_rdata_sh   = w_rdata_wide[31:0];
    sel_o        = phase_i ? w_sel_wide[7:4]     : w_sel_wide[3:0];
    wdata_o      = phase_i ? w_wdata_wide[63:32] : w_wdata_wide[31:0];
    case (size_i)
      SIZE_B:  rdata_o = unsigned_i ? {24'h0, w_rdata_sh[7:0]}
                                    : {{24{w_rdata_sh[7]}}, w_rdata_sh[7:0]};
      SIZE_H:  rdata_o = unsigned_i ? {16'h0, w_rdata_sh[15:0]}
                                    : {{16{w_rdata_sh[15]}}, w_rdata_sh[15:0]};
      default: rdata_o = w_rdata_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_ctrl
// Purpose  : Sequential load/store unit. Accepts one uop, runs it over a
//            req/gnt/rvalid bus while stalling the pipeline, and reports a
//            one-cycle completion with writeback data and exception flags.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              req_valid_i,
  input  alu_op_t           uop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  reg_addr_t         rd_wa_i,
  output logic              stall_req_o,
  output logic              done_o,
  output logic              rd_we_o,
  output reg_addr_t         rd_a_o,
  output logic [31:0]       rd_wd_o,
  output logic [2:0]        exc_o,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i
);

  lsu_state_e        state_q, state_d;
  logic              phase_q, phase_d;
  lsu_size_e         size_q, size_d;
  logic              store_q, store_d;
  logic              unsigned_q, unsigned_d;
  logic              split_q, split_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              done_q, done_d;
  logic              rd_we_q, rd_we_d;
  reg_addr_t         rd_a_q, rd_a_d;
  logic [31:0]       rd_wd_q, rd_wd_d;
  logic [2:0]        exc_q, exc_d;

  logic              w_accept;
  lsu_size_e         w_in_size;
  logic              w_misal;
  logic              w_cross;
  logic              w_expired;
  logic              w_second;
  logic [ADDR_W-1:0] w_bus_addr;
  logic [3:0]        w_lane_sel;
  logic [31:0]       w_lane_wdata;
  logic [31:0]       w_lane_rdata;

  // Decode the incoming uop and derive shared status terms.
  always_comb begin
    w_in_size  = op_size(uop_i);
    w_accept   = (state_q == LSU_IDLE) && req_valid_i && is_mem_op(uop_i);
    w_misal    = ((w_in_size == SIZE_H) && addr_i[0]) ||
                 ((w_in_size == SIZE_W) && (addr_i[1:0] != 2'b00));
    // A misaligned halfword at offset 1 still fits one word, so only
    // accesses that spill past lane 3 need a second bus transaction.
    w_cross    = (w_in_size == SIZE_W) || (addr_i[1:0] == 2'b11);
    w_expired  = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
    w_second   = split_q && phase_q;
    w_bus_addr = {addr_q[ADDR_W-1:2], 2'b00} + {{(ADDR_W-3){1'b0}}, phase_q, 2'b00};
  end

  lsu_lane u_lane (
    .size_i     (size_q),
    .offset_i   (addr_q[1:0]),
    .phase_i    (phase_q),
    .unsigned_i (unsigned_q),
    .wdata_i    (wdata_q),
    .rdata_lo_i (w_second ? rdata0_q : bus_rdata_i),
    .rdata_hi_i (w_second ? bus_rdata_i : 32'h0000_0000),
    .sel_o      (w_lane_sel),
    .wdata_o    (w_lane_wdata),
    .rdata_o    (w_lane_rdata)
  );

  // Next-state, completion results and combinational bus/stall outputs.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    size_d      = size_q;
    store_d     = store_q;
    unsigned_d  = unsigned_q;
    split_d     = split_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    to_cnt_d    = to_cnt_q;
    rd_a_d      = rd_a_q;
    rd_wd_d     = rd_wd_q;
    done_d      = 1'b0;
    rd_we_d     = 1'b0;
    exc_d       = 3'b000;
    stall_req_o = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_sel_o   = 4'b0000;
    bus_wdata_o = 32'h0000_0000;

    case (state_q)
      LSU_IDLE: begin
        if (w_accept) begin
          stall_req_o = 1'b1;
          size_d      = w_in_size;
          store_d     = is_store(uop_i);
          unsigned_d  = is_unsigned(uop_i);
          split_d     = MISALIGN_SPLIT && w_misal && w_cross;
          addr_d      = addr_i;
          wdata_d     = wdata_i;
          rd_a_d      = rd_wa_i;
          to_cnt_d    = '0;
          phase_d     = 1'b0;
          if (w_misal && !MISALIGN_SPLIT) begin
            state_d                 = LSU_DONE;
            done_d                  = 1'b1;
            rd_wd_d                 = 32'h0000_0000;
            exc_d[EXC_ST_MISALIGN]  = is_store(uop_i);
            exc_d[EXC_LD_MISALIGN]  = !is_store(uop_i);
          end else begin
            state_d = LSU_REQ;
          end
        end
      end

      LSU_REQ: begin
        stall_req_o = 1'b1;
        if (w_expired) begin
          state_d              = LSU_DONE;
          done_d               = 1'b1;
          rd_wd_d              = 32'h0000_0000;
          exc_d[EXC_ACC_FAULT] = 1'b1;
        end else begin
          bus_req_o   = 1'b1;
          bus_we_o    = store_q;
          bus_addr_o  = w_bus_addr;
          bus_sel_o   = w_lane_sel;
          bus_wdata_o = store_q ? w_lane_wdata : 32'h0000_0000;
          to_cnt_d    = to_cnt_q + TO_W'(1);
          if (bus_gnt_i) begin
            state_d = LSU_RESP;
          end
        end
      end

      LSU_RESP: begin
        stall_req_o = 1'b1;
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            state_d              = LSU_DONE;
            done_d               = 1'b1;
            rd_wd_d              = 32'h0000_0000;
            exc_d[EXC_ACC_FAULT] = 1'b1;
          end else if (split_q && !phase_q) begin
            rdata0_d = bus_rdata_i;
            phase_d  = 1'b1;
            to_cnt_d = to_cnt_q + TO_W'(1);
            state_d  = LSU_REQ;
          end else begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
            rd_we_d = !store_q;
            rd_wd_d = store_q ? 32'h0000_0000 : w_lane_rdata;
          end
        end else if (w_expired) begin
          state_d              = LSU_DONE;
          done_d               = 1'b1;
          rd_wd_d              = 32'h0000_0000;
          exc_d[EXC_ACC_FAULT] = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: begin
        // DONE: the pipeline advances this cycle, so a new uop is not taken.
        state_d = LSU_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q    <= LSU_IDLE;
      phase_q    <= 1'b0;
      size_q     <= SIZE_B;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      split_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      rdata0_q   <= 32'h0000_0000;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      rd_we_q    <= 1'b0;
      rd_a_q     <= '0;
      rd_wd_q    <= 32'h0000_0000;
      exc_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      size_q     <= size_d;
      store_q    <= store_d;
      unsigned_q <= unsigned_d;
      split_q    <= split_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      to_cnt_q   <= to_cnt_d;
      done_q     <= done_d;
      rd_we_q    <= rd_we_d;
      rd_a_q     <= rd_a_d;
      rd_wd_q    <= rd_wd_d;
      exc_q      <= exc_d;
    end
  end

  assign done_o  = done_q;
  assign rd_we_o = rd_we_q;
  assign rd_a_o  = rd_a_q;
  assign rd_wd_o = rd_wd_q;
  assign exc_o   = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bus_ctrl
// Purpose  : Scoreboard bench for lsu_bus_ctrl. Three instances cover
//            no-split (long timeout), split, and short-timeout builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_ctrl;
  import lsu_bus_ctrl_pkg::*;

  localparam int N_DUT = 3;

  typedef struct {
    int          dut;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_t;

  typedef struct {
    int          dut;
    logic        rd_we;
    reg_addr_t   rd_a;
    logic [31:0] rd_wd;
    logic        chk_wd;
    logic [2:0]  exc;
    int          cyc;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        req_valid [N_DUT];
  alu_op_t     uop;
  logic [31:0] addr;
  logic [31:0] wdata;
  reg_addr_t   rd_wa;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;

  logic        stall   [N_DUT];
  logic        done    [N_DUT];
  logic        rd_we   [N_DUT];
  reg_addr_t   rd_a    [N_DUT];
  logic [31:0] rd_wd   [N_DUT];
  logic [2:0]  exc     [N_DUT];
  logic        b_req   [N_DUT];
  logic        b_we    [N_DUT];
  logic [31:0] b_addr  [N_DUT];
  logic [3:0]  b_sel   [N_DUT];
  logic [31:0] b_wdata [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    lsu_bus_ctrl #(
      .ADDR_W         (32),
      .MISALIGN_SPLIT (g == 1),
      .TIMEOUT_CYCLES ((g == 2) ? 4 : 255),
      .TO_W           (8)
    ) u_dut (
      .clk_i        (clk),
      .n_rst_i      (n_rst),
      .req_valid_i  (req_valid[g]),
      .uop_i        (uop),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .rd_wa_i      (rd_wa),
      .stall_req_o  (stall[g]),
      .done_o       (done[g]),
      .rd_we_o      (rd_we[g]),
      .rd_a_o       (rd_a[g]),
      .rd_wd_o      (rd_wd[g]),
      .exc_o        (exc[g]),
      .bus_req_o    (b_req[g]),
      .bus_gnt_i    (gnt),
      .bus_we_o     (b_we[g]),
      .bus_addr_o   (b_addr[g]),
      .bus_sel_o    (b_sel[g]),
      .bus_wdata_o  (b_wdata[g]),
      .bus_rvalid_i (rvalid),
      .bus_rdata_i  (rdata),
      .bus_err_i    (err)
    );
  end

  bus_t  bus_q  [$];
  done_t done_q [$];
  int    n_cmp = 0;
  int    n_mis = 0;
  int    cyc   = 0;
  logic  rst_smp = 1'b1;
  logic  fin_req = 1'b0;
  logic  fin_ack = 1'b0;

  // Cycle counter and reset value seen by the DUT at each active edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_smp = n_rst;
    end
  end

  // Monitor: compares bus requests and completions against the scoreboard.
  initial begin
    bus_t  eb;
    done_t ed;
    int    stale;
    stale = 0;
    forever begin
      @(negedge clk);
      if (rst_smp === 1'b0) begin
        for (int d = 0; d < N_DUT; d++) begin
          n_cmp++;
          if (stall[d] !== 1'b0 || done[d] !== 1'b0 || rd_we[d] !== 1'b0 ||
              rd_a[d] !== '0 || rd_wd[d] !== '0 || exc[d] !== '0 ||
              b_req[d] !== 1'b0 || b_we[d] !== 1'b0 || b_addr[d] !== '0 ||
              b_sel[d] !== '0 || b_wdata[d] !== '0) begin
            n_mis++;
            $display("FAIL reset_zero dut%0d: stall=%b done=%b we=%b rd=%0d wd=%h exc=%b req=%b bwe=%b addr=%h sel=%b bwd=%h, required all zero",
                     d, stall[d], done[d], rd_we[d], rd_a[d], rd_wd[d], exc[d],
                     b_req[d], b_we[d], b_addr[d], b_sel[d], b_wdata[d]);
          end
        end
      end else begin
        for (int d = 0; d < N_DUT; d++) begin
          if (b_req[d] === 1'b1) begin
            n_cmp++;
            if (bus_q.size() == 0) begin
              n_mis++;
              $display("FAIL bus_req dut%0d: unexpected request addr=%h sel=%b", d, b_addr[d], b_sel[d]);
            end else begin
              eb = bus_q[0];
              if (eb.dut != d || b_we[d] !== eb.we || b_addr[d] !== eb.addr ||
                  b_sel[d] !== eb.sel || stall[d] !== 1'b1 ||
                  (eb.chk_wdata && b_wdata[d] !== eb.wdata)) begin
                n_mis++;
                $display("FAIL bus_req dut%0d: got we=%b addr=%h sel=%b wdata=%h stall=%b, required dut%0d we=%b addr=%h sel=%b wdata=%h stall=1",
                         d, b_we[d], b_addr[d], b_sel[d], b_wdata[d], stall[d],
                         eb.dut, eb.we, eb.addr, eb.sel, eb.wdata);
              end
              if (gnt === 1'b1) begin
                void'(bus_q.pop_front());
                stale = 0;
              end
            end
          end
          if (done[d] === 1'b1) begin
            n_cmp++;
            if (done_q.size() == 0) begin
              n_mis++;
              $display("FAIL done dut%0d: unexpected completion wd=%h exc=%b", d, rd_wd[d], exc[d]);
            end else begin
              ed = done_q.pop_front();
              stale = 0;
              if (ed.dut != d || rd_we[d] !== ed.rd_we || rd_a[d] !== ed.rd_a ||
                  exc[d] !== ed.exc || (ed.chk_wd && rd_wd[d] !== ed.rd_wd) ||
                  (ed.cyc >= 0 && cyc != ed.cyc)) begin
                n_mis++;
                $display("FAIL done dut%0d: got we=%b rd=%0d wd=%h exc=%b cyc=%0d, required dut%0d we=%b rd=%0d wd=%h exc=%b cyc=%0d",
                         d, rd_we[d], rd_a[d], rd_wd[d], exc[d], cyc,
                         ed.dut, ed.rd_we, ed.rd_a, ed.rd_wd, ed.exc, ed.cyc);
              end
            end
          end
        end
      end
      if (bus_q.size() != 0 || done_q.size() != 0) begin
        stale++;
        if (stale > 200) begin
          n_cmp++;
          n_mis++;
          $display("FAIL watchdog: %0d bus and %0d done expectations never observed, required 0",
                   bus_q.size(), done_q.size());
          bus_q.delete();
          done_q.delete();
          stale = 0;
        end
      end else begin
        stale = 0;
      end
      if (fin_req && !fin_ack) begin
        n_cmp++;
        if (bus_q.size() != 0 || done_q.size() != 0) begin
          n_mis++;
          $display("FAIL leftover: %0d bus and %0d done expectations pending, required 0",
                   bus_q.size(), done_q.size());
        end
        fin_ack = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_bus(input int d, input logic we, input logic [31:0] a,
                         input logic [3:0] sel, input logic [31:0] wd);
    bus_q.push_back('{d, we, a, sel, wd, we});
  endtask

  task automatic exp_done(input int d, input logic we, input reg_addr_t rd,
                          input logic [31:0] wd, input logic [2:0] e, input int c);
    done_q.push_back('{d, we, rd, wd, we, e, c});
  endtask

  // Present a uop for one cycle; returns the cycle count right after acceptance.
  task automatic issue(input int d, input alu_op_t op, input logic [31:0] a,
                       input logic [31:0] wd, input reg_addr_t rd, output int acc);
    req_valid[d] = 1'b1;
    uop   = op;
    addr  = a;
    wdata = wd;
    rd_wa = rd;
    step();
    req_valid[d] = 1'b0;
    uop   = UOP_NOP;
    addr  = '0;
    wdata = '0;
    rd_wa = '0;
    acc   = cyc;
  endtask

  // Grant after gdly cycles, then optionally respond one cycle later.
  task automatic xact(input int gdly, input logic [31:0] rd, input logic e,
                      input logic resp);
    for (int i = 0; i < gdly; i++) step();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    if (resp) begin
      rvalid = 1'b1;
      rdata  = rd;
      err    = e;
      step();
      rvalid = 1'b0;
      rdata  = '0;
      err    = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus_q.size() != 0 || done_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    step();
    step();
  endtask

  task automatic load1(input int d, input alu_op_t op, input logic [31:0] a,
                       input logic [3:0] sel, input reg_addr_t rd,
                       input logic [31:0] bus_data, input logic [31:0] exp_wd);
    int acc;
    exp_bus(d, 1'b0, {a[31:2], 2'b00}, sel, 32'h0);
    issue(d, op, a, 32'h0, rd, acc);
    exp_done(d, 1'b1, rd, exp_wd, 3'b000, acc + 2);
    xact(0, bus_data, 1'b0, 1'b1);
    drain();
  endtask

  task automatic store1(input int d, input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] sel,
                        input logic [31:0] exp_bwd);
    int acc;
    exp_bus(d, 1'b1, {a[31:2], 2'b00}, sel, exp_bwd);
    issue(d, op, a, wd, 5'd0, acc);
    exp_done(d, 1'b0, 5'd0, 32'h0, 3'b000, acc + 2);
    xact(0, 32'h0, 1'b0, 1'b1);
    drain();
  endtask

  task automatic misal(input int d, input alu_op_t op, input logic [31:0] a,
                       input reg_addr_t rd, input logic [2:0] e);
    int acc;
    issue(d, op, a, 32'h0, rd, acc);
    exp_done(d, 1'b0, rd, 32'h0, e, acc);
    drain();
  endtask

  // Directed stimulus.
  initial begin
    int acc;
    n_rst  = 1'b0;
    uop    = UOP_NOP;
    addr   = '0;
    wdata  = '0;
    rd_wa  = '0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    err    = 1'b0;
    rdata  = '0;
    for (int d = 0; d < N_DUT; d++) req_valid[d] = 1'b0;
    repeat (3) step();
    n_rst = 1'b1;
    step();

    // Aligned loads with lane steering and extension.
    load1(0, UOP_LW,  32'h100, 4'b1111, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    load1(0, UOP_LB,  32'h103, 4'b1000, 5'd6, 32'h80123456, 32'hFFFFFF80);
    load1(0, UOP_LBU, 32'h103, 4'b1000, 5'd7, 32'h80123456, 32'h00000080);
    load1(0, UOP_LH,  32'h102, 4'b1100, 5'd8, 32'hBEEF1234, 32'hFFFFBEEF);

    // Stores with byte-lane steering.
    store1(0, UOP_SH, 32'h202, 32'h00001234, 4'b1100, 32'h12340000);
    store1(0, UOP_SB, 32'h201, 32'h000000AB, 4'b0010, 32'h0000AB00);
    store1(0, UOP_SW, 32'h300, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    // Misaligned without splitting: immediate exception, no bus traffic.
    misal(0, UOP_LW, 32'h101, 5'd9, 3'b010);
    misal(0, UOP_SW, 32'h102, 5'd0, 3'b001);
    misal(0, UOP_SH, 32'h101, 5'd0, 3'b001);
    misal(2, UOP_LH, 32'h203, 5'd3, 3'b010);

    // Split misaligned load.
    exp_bus(1, 1'b0, 32'h100, 4'b1110, 32'h0);
    exp_bus(1, 1'b0, 32'h104, 4'b0001, 32'h0);
    issue(1, UOP_LW, 32'h101, 32'h0, 5'd10, acc);
    exp_done(1, 1'b1, 5'd10, 32'h55443322, 3'b000, acc + 4);
    xact(0, 32'h44332211, 1'b0, 1'b1);
    xact(0, 32'h88776655, 1'b0, 1'b1);
    drain();

    // Split misaligned store.
    exp_bus(1, 1'b1, 32'h100, 4'b1000, 32'hDD000000);
    exp_bus(1, 1'b1, 32'h104, 4'b0111, 32'h00AABBCC);
    issue(1, UOP_SW, 32'h103, 32'hAABBCCDD, 5'd0, acc);
    exp_done(1, 1'b0, 5'd0, 32'h0, 3'b000, acc + 4);
    xact(0, 32'h0, 1'b0, 1'b1);
    xact(0, 32'h0, 1'b0, 1'b1);
    drain();

    // Grant withheld for 10 cycles: request must hold steady.
    exp_bus(0, 1'b0, 32'h400, 4'b1111, 32'h0);
    issue(0, UOP_LW, 32'h400, 32'h0, 5'd11, acc);
    exp_done(0, 1'b1, 5'd11, 32'h11112222, 3'b000, acc + 12);
    xact(10, 32'h11112222, 1'b0, 1'b1);
    drain();

    // Response timeout on the short-timeout build.
    exp_bus(2, 1'b0, 32'h500, 4'b1111, 32'h0);
    issue(2, UOP_LW, 32'h500, 32'h0, 5'd12, acc);
    exp_done(2, 1'b0, 5'd12, 32'h0, 3'b100, -1);
    xact(0, 32'h0, 1'b0, 1'b0);
    drain();

    // Bus error response.
    exp_bus(0, 1'b0, 32'h700, 4'b1111, 32'h0);
    issue(0, UOP_LW, 32'h700, 32'h0, 5'd13, acc);
    exp_done(0, 1'b0, 5'd13, 32'h0, 3'b100, acc + 2);
    xact(0, 32'h12345678, 1'b1, 1'b1);
    drain();

    // Non-memory op is ignored.
    req_valid[0] = 1'b1;
    uop = 8'h05;
    repeat (2) step();
    req_valid[0] = 1'b0;
    uop = UOP_NOP;
    step();

    // Reset while waiting for a response, then a stray rvalid in IDLE.
    exp_bus(0, 1'b0, 32'h800, 4'b1111, 32'h0);
    issue(0, UOP_LW, 32'h800, 32'h0, 5'd14, acc);
    xact(0, 32'h0, 1'b0, 1'b0);
    n_rst = 1'b0;
    repeat (2) step();
    n_rst = 1'b1;
    step();
    rvalid = 1'b1;
    rdata  = 32'hFEEDFACE;
    repeat (2) step();
    rvalid = 1'b0;
    rdata  = '0;
    repeat (3) step();

    // Unit still operational afterwards.
    load1(0, UOP_LHU, 32'h106, 4'b1100, 5'd15, 32'h7FFF0000, 32'h00007FFF);

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !fin_ack; i++) step();
    if (!fin_ack) begin
      $display("FAIL final: monitor handshake missing, required ack");
      $fatal(1, "monitor did not respond");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
